// File: rtl/fmul_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fmul_arbiter_pkg
// Shared accelerator package: FP32 width, default multiplier latency, the
// {valid, idx} tag carried alongside each multiply, and a one-hot to index
// helper used by the arbiter.
// -----------------------------------------------------------------------------
package fmul_arbiter_pkg;

    localparam int FP_W        = 32;
    localparam int MUL_LAT_DEF = 4;
    localparam int MAX_REQ     = 8;
    localparam int IDX_W       = 3;   // enough for up to MAX_REQ requesters

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Encode a one-hot (or all-zero) vector into a requester index.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fmul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fmul_arbiter_if
// Requester-side bus of the shared FP32 multiplier arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot grant)
//   req_a/req_b         : packed operands, slice i = bits [32i+31:32i]
//   rsp_valid/rsp_z     : one-cycle one-hot result strobe and result value
// Modports: master = requesters, slave = arbiter.
// -----------------------------------------------------------------------------
interface fmul_arbiter_if
    import fmul_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [FP_W-1:0]      rsp_z;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_z
    );

endinterface

// File: rtl/fmul_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: gnt is one-hot on the first set req bit
// strictly after ptr, searching modulo NREQ; zero when req is zero.
//   req : request vector
//   ptr : index granted last
//   gnt : one-hot grant
// -----------------------------------------------------------------------------
module rr_arbiter
    import fmul_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    logic [NREQ-1:0] gnt_s;
    logic            found_s;

    // Two ascending passes: indices above ptr first, then wrap to 0..ptr.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && req[i] && (i > int'(ptr))) begin
                gnt_s[i] = 1'b1;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && req[i] && (i <= int'(ptr))) begin
                gnt_s[i] = 1'b1;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/fmul_arbiter.sv
// -----------------------------------------------------------------------------
// fmul_arbiter
// Shares one external FP32 multiplier (latency MUL_LAT) among NREQ requesters
// with round-robin grant and an in-order tag pipeline that steers each result
// back to its requester 1+MUL_LAT cycles after issue.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   bus (slave)       : requester handshake, operands and result strobe
//   mul_a, mul_b      : registered operands to the shared multiplier
//   mul_z             : multiplier result
//   busy              : any operation in flight
// Optional (macro FMUL_ARB_PERF_EN): perf_issue_cnt, perf_stall_cnt, 32-bit
// saturating counters of issues and of cycles with a stalled requester.
// The multiplier lives in the accelerator top and takes ~rst as its
// active-high reset.
// -----------------------------------------------------------------------------
module fmul_arbiter
    import fmul_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    fmul_arbiter_if.slave   bus,
    output logic [FP_W-1:0] mul_a,
    output logic [FP_W-1:0] mul_b,
    input  logic [FP_W-1:0] mul_z,
`ifdef FMUL_ARB_PERF_EN
    output logic [31:0]     perf_issue_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic            busy
);

    logic [IDX_W-1:0]   ptr_r;
    logic [NREQ-1:0]    gnt_s;
    logic [NREQ-1:0]    ready_s;
    logic [MAX_REQ-1:0] gnt_wide_s;
    logic               issue_s;
    logic [IDX_W-1:0]   issue_idx_s;
    logic [FP_W-1:0]    a_sel_s;
    logic [FP_W-1:0]    b_sel_s;
    tag_t               tag_r [MUL_LAT+1];
    logic [NREQ-1:0]    rsp_valid_s;
    logic [FP_W-1:0]    rsp_z_s;
    logic               busy_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req (bus.req_valid),
        .ptr (ptr_r),
        .gnt (gnt_s)
    );

    // Grant is suppressed while reset is held; select the granted operands.
    always_comb begin
        if (rst) begin
            ready_s = gnt_s;
        end else begin
            ready_s = '0;
        end
        gnt_wide_s             = '0;
        gnt_wide_s[NREQ-1:0]   = ready_s;
        issue_s                = |(bus.req_valid & ready_s);
        issue_idx_s            = onehot_to_idx(gnt_wide_s);
        a_sel_s                = '0;
        b_sel_s                = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready_s[i]) begin
                a_sel_s = bus.req_a[i*FP_W +: FP_W];
                b_sel_s = bus.req_b[i*FP_W +: FP_W];
            end else begin
                a_sel_s = a_sel_s;
            end
        end
    end

    assign bus.req_ready = ready_s;

    // Pointer and multiplier operand registers, updated only on issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= IDX_W'(NREQ - 1);
            mul_a <= '0;
            mul_b <= '0;
        end else if (issue_s) begin
            ptr_r <= issue_idx_s;
            mul_a <= a_sel_s;
            mul_b <= b_sel_s;
        end else begin
            ptr_r <= ptr_r;
            mul_a <= mul_a;
            mul_b <= mul_b;
        end
    end

    // Tag pipeline: stage MUL_LAT lines up with mul_z for the same operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0].valid <= issue_s;
            tag_r[0].idx   <= issue_idx_s;
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Result steering from the last tag stage; busy is any live tag.
    always_comb begin
        rsp_valid_s = '0;
        rsp_z_s     = '0;
        busy_s      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_s[i] = tag_r[MUL_LAT].valid && (int'(tag_r[MUL_LAT].idx) == i);
        end
        if (tag_r[MUL_LAT].valid) begin
            rsp_z_s = mul_z;
        end else begin
            rsp_z_s = '0;
        end
        for (int i = 0; i <= MUL_LAT; i++) begin
            busy_s = busy_s | tag_r[i].valid;
        end
    end

    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_z     = rsp_z_s;
    assign busy          = busy_s;

`ifdef FMUL_ARB_PERF_EN
    logic [31:0] perf_issue_r;
    logic [31:0] perf_stall_r;
    logic        stall_s;

    assign stall_s = |(bus.req_valid & ~ready_s);

    // Saturating issue and stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_r <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (issue_s && (perf_issue_r != 32'hFFFF_FFFF)) begin
                perf_issue_r <= perf_issue_r + 32'd1;
            end else begin
                perf_issue_r <= perf_issue_r;
            end
            if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end

    assign perf_issue_cnt = perf_issue_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fmul_arbiter
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the arbiter; a behavioural FP32 multiplier stands in for the
// accelerator's shared multiplier.
// -----------------------------------------------------------------------------
module tb_fmul_arbiter;
    import fmul_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mul_a, mul_b, mul_z;
    logic        busy;
`ifdef FMUL_ARB_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    fmul_arbiter_if #(.NREQ(NREQ)) bus ();

    fmul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_z (mul_z),
`ifdef FMUL_ARB_PERF_EN
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // FP32 helpers via double precision (operands are normal, products exact)
    function automatic real fp32_to_real(input logic [31:0] x);
        logic [63:0] d;
        d = {x[31], ({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_fp32(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        return real_to_fp32(fp32_to_real(a) * fp32_to_real(b));
    endfunction

    // Shared multiplier stand-in: MUL_LAT register stages
    logic [31:0] zp [MUL_LAT];
    always @(posedge clk) begin
        zp[0] <= fmul_ref(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) zp[i] <= zp[i-1];
    end
    assign mul_z = zp[MUL_LAT-1];

    // Reference model state
    typedef struct {
        int          idx;
        logic [31:0] z;
        int          due;
    } exp_t;

    exp_t            q[$];
    int              cyc, obs_cyc, ptr_m;
    int              issue_m, stall_m;
    logic [31:0]     mul_a_e, mul_b_e;
    logic [NREQ-1:0] v_in;
    logic [31:0]     a_in [NREQ];
    logic [31:0]     b_in [NREQ];
    logic [NREQ-1:0] ready_obs, rsp_obs;
    logic [31:0]     z_obs;
    logic            busy_obs;
    int              checks = 0;
    int              errors = 0;
    logic [31:0]     tbl [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000,
                                 32'h3F000000, 32'hC0000000, 32'h3FC00000, 32'hBF400000};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.req_valid = v_in;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*32 +: 32] = a_in[i];
            bus.req_b[i*32 +: 32] = b_in[i];
        end
    endtask

    task automatic reset_model();
        q.delete();
        ptr_m   = NREQ - 1;
        mul_a_e = 32'd0;
        mul_b_e = 32'd0;
        issue_m = 0;
        stall_m = 0;
    endtask

    // One clock: compare at negedge, advance the model at posedge.
    task automatic tick();
        logic [NREQ-1:0] gnt_e, rsp_e;
        logic [31:0]     z_e;
        logic            busy_e;
        int              gi, j;
        drive();
        @(negedge clk);
        obs_cyc = cyc;
        gi = -1;
        if (rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (ptr_m + k) % NREQ;
                if (gi < 0 && v_in[j]) gi = j;
            end
        end
        gnt_e = '0;
        if (gi >= 0) gnt_e[gi] = 1'b1;
        busy_e = (q.size() != 0);
        rsp_e  = '0;
        z_e    = 32'd0;
        if (q.size() != 0 && q[0].due == cyc) begin
            rsp_e[q[0].idx] = 1'b1;
            z_e = q[0].z;
            void'(q.pop_front());
        end
        ready_obs = bus.req_ready;
        rsp_obs   = bus.rsp_valid;
        z_obs     = bus.rsp_z;
        busy_obs  = busy;
        check_eq("req_ready", 32'(ready_obs), 32'(gnt_e));
        check_eq("rsp_valid", 32'(rsp_obs), 32'(rsp_e));
        check_eq("rsp_z", z_obs, z_e);
        check_eq("busy", 32'(busy_obs), 32'(busy_e));
        check_eq("mul_a", mul_a, mul_a_e);
        check_eq("mul_b", mul_b, mul_b_e);
`ifdef FMUL_ARB_PERF_EN
        check_eq("perf_issue", perf_issue_cnt, 32'(issue_m));
        check_eq("perf_stall", perf_stall_cnt, 32'(stall_m));
`endif
        @(posedge clk);
        if (gi >= 0) begin
            q.push_back('{idx: gi, z: fmul_ref(a_in[gi], b_in[gi]), due: cyc + 1 + MUL_LAT});
            ptr_m   = gi;
            mul_a_e = a_in[gi];
            mul_b_e = b_in[gi];
            issue_m++;
        end
        if (rst && ((v_in & ~gnt_e) != '0)) stall_m++;
        cyc++;
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = tbl[$urandom_range(0, 7)];
            b_in[i] = tbl[$urandom_range(0, 7)];
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        reset_model();
        v_in = '1;            // grants must stay low while held in reset
        repeat (2) tick();
        rst  = 1'b1;
        v_in = '0;
    endtask

    initial begin
        int n, nr;
        int r [4];
        logic [31:0] i0, s0;
        cyc = 0;
        v_in = '0;
        for (int i = 0; i < NREQ; i++) begin a_in[i] = 32'd0; b_in[i] = 32'd0; end
        drive();
        reset_model();
        #1;
        do_reset();

        // All four requesters valid: grants rotate 0,1,2,3,0,...
        v_in = '1;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            tick();
            check_eq("rr_all_grant", 32'(ready_obs), 32'(1) << (k % NREQ));
        end
        v_in = '0;
        repeat (MUL_LAT + 2) tick();

        // Single request 0: 2.0 * 3.0
        a_in[0] = 32'h40000000; b_in[0] = 32'h40400000; v_in = 4'b0001;
        tick();
        v_in = '0;
        repeat (MUL_LAT) tick();
        tick();
        check_eq("single_rsp_valid", 32'(rsp_obs), 32'h1);
        check_eq("single_rsp_z", z_obs, 32'h40C00000);
        repeat (2) tick();

        // Three issues, two idle cycles, then reset mid-flight
        v_in = '1;
        repeat (3) begin rand_ops(); tick(); end
        v_in = '0;
        repeat (2) tick();
        do_reset();
        repeat (MUL_LAT + 3) begin
            tick();
            check_eq("post_reset_no_rsp", 32'(rsp_obs), 32'h0);
        end
        check_eq("post_reset_busy", 32'(busy_obs), 32'h0);
        v_in = '1;
        rand_ops();
        tick();
        check_eq("post_reset_grant0", 32'(ready_obs), 32'h1);
        v_in = '0;
        repeat (MUL_LAT + 2) tick();

        // Issues on cycle n and n+2 from requester 2
        n = cyc; nr = 0;
        for (int k = 0; k < 4; k++) r[k] = -1;
        for (int s = 0; s < MUL_LAT + 8; s++) begin
            v_in = (s == 0 || s == 2) ? 4'b0100 : 4'b0000;
            rand_ops();
            tick();
            if (rsp_obs != '0) begin
                if (nr < 4) r[nr] = obs_cyc - n;
                nr++;
            end
            if (obs_cyc == n + 2 + MUL_LAT) check_eq("gap_busy_mid", 32'(busy_obs), 32'h1);
            if (obs_cyc == n + 3 + MUL_LAT) check_eq("gap_busy_last", 32'(busy_obs), 32'h1);
            if (obs_cyc == n + 4 + MUL_LAT) check_eq("gap_busy_idle", 32'(busy_obs), 32'h0);
        end
        check_eq("gap_rsp_count", 32'(nr), 32'd2);
        check_eq("gap_rsp_first", 32'(r[0]), 32'(1 + MUL_LAT));
        check_eq("gap_rsp_second", 32'(r[1]), 32'(3 + MUL_LAT));

        // Only 1 and 3 valid with ptr=3: grants 1,3,1,3; 1.0 * 5.0
        do_reset();
        a_in[1] = 32'h3F800000; b_in[1] = 32'h40A00000;
        a_in[3] = 32'h3F800000; b_in[3] = 32'h40A00000;
        for (int k = 0; k < 4 + MUL_LAT + 2; k++) begin
            v_in = (k < 4) ? 4'b1010 : 4'b0000;
            tick();
            if (k < 4) check_eq("odd_grant", 32'(ready_obs), (k % 2 == 0) ? 32'h2 : 32'h8);
            if (rsp_obs != '0) check_eq("odd_rsp_z", z_obs, 32'h40A00000);
        end

        // Randomized traffic, including requests that drop without a grant
        for (int k = 0; k < 400; k++) begin
            v_in = NREQ'($urandom);
            rand_ops();
            tick();
        end
        v_in = '0;
        repeat (MUL_LAT + 2) tick();

`ifdef FMUL_ARB_PERF_EN
        // Three requesters valid for ten cycles
        i0 = perf_issue_cnt;
        s0 = perf_stall_cnt;
        v_in = 4'b0111;
        repeat (10) begin rand_ops(); tick(); end
        v_in = '0;
        check_eq("perf_issue_delta", perf_issue_cnt - i0, 32'd10);
        check_eq("perf_stall_delta", perf_stall_cnt - s0, 32'd10);
        repeat (MUL_LAT + 2) tick();
`else
        i0 = 32'd0;
        s0 = 32'd0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one FP32 multiplier (1..8).
REQ-002 The block SHALL have parameter MUL_LAT, default 4, giving the multiplier latency in cycles from operands presented to mul_z valid (>=1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester grant, at most one bit high.
REQ-007 The block SHALL have port req_a, input, NREQ*32 bits: operand A per requester, slice i = bits [32i+31:32i].
REQ-008 The block SHALL have port req_b, input, NREQ*32 bits: operand B per requester, same slicing as req_a.
REQ-009 The block SHALL have port rsp_valid, output, NREQ bits: one-cycle one-hot result strobe; no backpressure.
REQ-010 The block SHALL have port rsp_z, output, 32 bits: the result, valid when any rsp_valid bit is high.
REQ-011 The block SHALL have ports mul_a and mul_b, output, 32 bits each: registered operands to the shared multiplier.
REQ-012 The block SHALL have port mul_z, input, 32 bits: the multiplier result.
REQ-013 The block SHALL have port busy, output, 1 bit: high while any operation is in flight.

Function
REQ-014 The grant SHALL be round-robin: req_ready is one-hot on the first valid index strictly after ptr, searching modulo NREQ; ptr is the last granted index.
REQ-015 req_ready SHALL be combinational from req_valid and ptr, and SHALL be zero when no request is valid.
REQ-016 An issue SHALL occur when req_valid[i] and req_ready[i] are both high; at most one issue per cycle, accepted every cycle.
REQ-017 On issue, ptr SHALL be set to i, and mul_a/mul_b SHALL register req_a/req_b slice i at the next clock edge; with no issue they SHALL hold their values.
REQ-018 A tag pipeline of depth 1+MUL_LAT SHALL carry {valid, requester index} alongside each issue.
REQ-019 rsp_valid[i] SHALL pulse exactly 1+MUL_LAT cycles after the issue handshake edge, with rsp_z = mul_z in that cycle; rsp_z SHALL be 0 when no rsp_valid bit is high.
REQ-020 Results SHALL return in issue order; back-to-back issues SHALL yield back-to-back responses.
REQ-021 ptr wrap-around SHALL run from NREQ-1 to 0; with NREQ=1 the sole requester is granted whenever it is valid.
REQ-022 busy SHALL be the OR of all tag-pipeline valid bits.
REQ-023 A requester dropping req_valid without a handshake SHALL have no effect on ptr or on the pipeline.

Reset
REQ-024 While rst is low: req_ready=0, rsp_valid=0, rsp_z=0, mul_a=mul_b=0, busy=0, all tag valids=0, ptr=NREQ-1 (requester 0 is granted first).
REQ-025 A reset asserted mid-operation SHALL discard every in-flight operation; no rsp_valid SHALL appear for those operations after release.
REQ-026 The shared multiplier instance SHALL receive reset as ~rst, since it is active-high.

Configuration
REQ-027 With macro FMUL_ARB_PERF_EN defined, the block SHALL add perf_issue_cnt and perf_stall_cnt as 32-bit outputs.
 - perf_issue_cnt counts issues.
 - perf_stall_cnt counts cycles in which any req_valid[i] is high while req_ready[i] is low.
 - Both counters saturate at 0xFFFFFFFF and reset to 0.
REQ-028 Without FMUL_ARB_PERF_EN, the counter ports and logic SHALL be absent and the block SHALL otherwise behave identically.

Structure
REQ-029 A shared accelerator package SHALL hold the FP32 width constant (32), the default MUL_LAT, and the tag struct {valid, idx}.
REQ-030 The round-robin grant SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt).
REQ-031 The multiplier SHALL be instantiated outside this block in the accelerator top.

Verification
REQ-032 Bench: single request 0, a=0x40000000, b=0x40400000 -> rsp_valid[0] 1+MUL_LAT cycles later, rsp_z=0x40C00000.
REQ-033 Bench: all four requesters valid continuously -> grants in order 0,1,2,3,0,...; responses in the same order, one per cycle.
REQ-034 Bench: only requesters 1 and 3 valid, ptr=3 -> grants 1,3,1,3; rsp_z=0x40A00000 for a=0x3F800000, b=0x40A00000.
REQ-035 Bench: assert rst two cycles after issuing three operations -> no rsp_valid afterwards; busy=0; first post-reset grant goes to requester 0.
REQ-036 Bench: issue on cycle n and cycle n+2 -> rsp_valid on cycles n+1+MUL_LAT and n+3+MUL_LAT; busy low only after the last.
REQ-037 Bench (FMUL_ARB_PERF_EN): three requesters valid for 10 cycles -> perf_issue_cnt=10, perf_stall_cnt=10.
